dmp_gather_reducer: RTL and testbench

- Successor to the per-thread DMP serialiser in the DMP-serial pagerank path.
- Collects per-thread pre-damp rank vectors from NUM_HW_THREADS local-update threads and reduces them across threads, one node-slice at a time.
- Streams the summed vector to the pagerank compute stage, LANES nodes per beat, under a valid/ready handshake.
- Improvements over the existing serialiser: parametrised lane count and data width, back-pressure support, partial-beat masking, abort on iteration change, and optional overflow saturation.

---
 rtl/pagerank_pkg.sv | 16 +
 rtl/dmp_lane_adder.sv | 39 +++
 rtl/dmp_gather_reducer.sv | 134 +++++++++++++
 tb/tb_dmp_gather_reducer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pagerank_pkg.sv
// Shared types and helpers for the DMP pagerank reduction path.
package pagerank_pkg;

  localparam int RANK_W = 64;
  typedef logic [RANK_W-1:0] rank_t;

  // Unsigned fixed point with 32 fractional bits.
  localparam rank_t RANK_ONE = 64'h0000_0001_0000_0000;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} reducer_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/dmp_lane_adder.sv
// One-lane cross-thread adder. DMP_REDUCE_SATURATE_EN selects saturating
// sums with an overflow flag; otherwise the sum wraps and sat stays 0.
module dmp_lane_adder
  import pagerank_pkg::*;
#(
  parameter int NUM_HW_THREADS = 8,
  parameter int DATA_W         = 64
) (
  input  logic [NUM_HW_THREADS-1:0][DATA_W-1:0] addends,
  output logic [DATA_W-1:0]                     sum,
  output logic                                  sat
);

`ifdef DMP_REDUCE_SATURATE_EN
  // Headroom bits so the full sum of all threads never wraps.
  localparam int ACC_W = DATA_W + $clog2(NUM_HW_THREADS);
  localparam logic [ACC_W-1:0] MAX_V = ACC_W'({DATA_W{1'b1}});

  logic [ACC_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int t = 0; t < NUM_HW_THREADS; t++)
      acc = acc + ACC_W'(addends[t]);
  end

  assign sat = (acc > MAX_V);
  assign sum = sat ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
`else
  always_comb begin
    sum = '0;
    for (int t = 0; t < NUM_HW_THREADS; t++)
      sum = sum + addends[t];
  end

  assign sat = 1'b0;
`endif

endmodule

// File: rtl/dmp_gather_reducer.sv
// Cross-thread reduction of pre-damp rank vectors, streamed LANES nodes per
// beat. Saturation is enabled by DMP_REDUCE_SATURATE_EN (see dmp_lane_adder).
module dmp_gather_reducer
  import pagerank_pkg::*;
#(
  parameter int NUM_HW_THREADS = 8,
  parameter int NODES_IN_GRAPH = 32,
  parameter int LANES          = 4,
  parameter int DATA_W         = 64
) (
  input  logic                                                   clock,
  input  logic                                                   reset_n,
  input  logic                                                   next_iteration,
  input  logic [NUM_HW_THREADS-1:0]                              thread_done,
  input  logic [NUM_HW_THREADS-1:0][NODES_IN_GRAPH-1:0][DATA_W-1:0] pre_damp,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [LANES-1:0][DATA_W-1:0]                           out_data,
  output logic [LANES-1:0]                                       out_lane_mask,
  output logic [31:0]                                            out_base_id,
  output logic                                                   out_last,
  output logic                                                   stream_start,
  output logic                                                   stream_done,
  output logic                                                   busy,
  output logic                                                   overflow
);

  localparam int NBEATS = ceil_div(NODES_IN_GRAPH, LANES);
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int IW     = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;

  reducer_state_t state, state_nxt;
  logic [NUM_HW_THREADS-1:0] done_mask;
  logic [BW-1:0] beat, load_beat;
  logic all_done, hs, load;
  logic [LANES-1:0][NUM_HW_THREADS-1:0][DATA_W-1:0] gath;
  logic [LANES-1:0][DATA_W-1:0] lane_sum;
  logic [LANES-1:0] lane_sat, lane_vld;

  assign all_done  = &(done_mask | thread_done);
  assign hs        = out_valid & out_ready;
  assign load_beat = (state == IDLE) ? '0 : beat + 1'b1;
  assign load      = !next_iteration &&
                     ((state == IDLE && all_done) || (state == STREAM && hs && !out_last));

  // Live gather of the beat about to be loaded; padding lanes feed zeros.
  always_comb begin : gather
    int node;
    node     = 0;
    gath     = '0;
    lane_vld = '0;
    for (int l = 0; l < LANES; l++) begin
      node = int'(load_beat) * LANES + l;
      if (node < NODES_IN_GRAPH) begin
        lane_vld[l] = 1'b1;
        for (int t = 0; t < NUM_HW_THREADS; t++)
          gath[l][t] = pre_damp[t][IW'(node)];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dmp_lane_adder #(
      .NUM_HW_THREADS(NUM_HW_THREADS),
      .DATA_W        (DATA_W)
    ) u_add (
      .addends(gath[l]),
      .sum    (lane_sum[l]),
      .sat    (lane_sat[l])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (next_iteration) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (all_done)        state_nxt = STREAM;
        STREAM:  if (hs && out_last)  state_nxt = DONE;
        default: ;
      endcase
    end
  end

  always_comb busy = (state == STREAM);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      done_mask     <= '0;
      beat          <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_lane_mask <= '0;
      out_base_id   <= '0;
      out_last      <= 1'b0;
      stream_start  <= 1'b0;
      stream_done   <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      stream_done <= 1'b0;
      // Abort wins over any handshake presented in the same cycle.
      if (next_iteration) begin
        done_mask    <= '0;
        out_valid    <= 1'b0;
        out_last     <= 1'b0;
        stream_start <= 1'b0;
      end else begin
        if (state == IDLE) done_mask <= done_mask | thread_done;
        if (hs) stream_start <= 1'b0;
        if (hs && out_last) begin
          out_valid   <= 1'b0;
          out_last    <= 1'b0;
          stream_done <= 1'b1;
        end
        if (load) begin
          beat          <= load_beat;
          out_valid     <= 1'b1;
          out_data      <= lane_sum;
          out_lane_mask <= lane_vld;
          out_base_id   <= 32'(int'(load_beat) * LANES);
          out_last      <= (load_beat == BW'(NBEATS - 1));
          overflow      <= overflow | (|(lane_sat & lane_vld));
          if (state == IDLE) stream_start <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmp_gather_reducer.sv
// Randomized bench for dmp_gather_reducer against a cycle-level behavioural model.
module tb_dmp_gather_reducer;
  import pagerank_pkg::RANK_ONE;

  localparam int T  = 8;
  localparam int N  = 30;
  localparam int L  = 4;
  localparam int W  = 64;
  localparam int NB = (N + L - 1) / L;
  localparam int DW = L * W;
  localparam logic [W+7:0] MAXV = {8'd0, {W{1'b1}}};

  logic clock = 1'b0;
  logic reset_n, next_iteration, out_ready;
  logic [T-1:0] thread_done;
  logic [T-1:0][N-1:0][W-1:0] pre_damp;
  logic out_valid, out_last, stream_start, stream_done, busy, overflow;
  logic [L-1:0][W-1:0] out_data;
  logic [L-1:0] out_lane_mask;
  logic [31:0] out_base_id;

  logic [W-1:0] pd [T][N];
  int errors = 0, checks = 0;
  int rdy_mode = 0, bp = 0, dut_hs = 0;

  // model state
  bit m_live = 0, m_clear = 0, m_done = 0, m_ovf = 0;
  int m_phase = 0, m_beat = 0;
  logic [T-1:0] m_mask = '0;

  dmp_gather_reducer #(
    .NUM_HW_THREADS(T), .NODES_IN_GRAPH(N), .LANES(L), .DATA_W(W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .next_iteration(next_iteration),
    .thread_done(thread_done), .pre_damp(pre_damp), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_lane_mask(out_lane_mask),
    .out_base_id(out_base_id), .out_last(out_last), .stream_start(stream_start),
    .stream_done(stream_done), .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  always_comb begin
    pre_damp = '0;
    for (int t = 0; t < T; t++)
      for (int n = 0; n < N; n++)
        pre_damp[t][n] = pd[t][n];
  end

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W+7:0] lane_raw(int b, int l);
    logic [W+7:0] s;
    int n;
    s = '0;
    n = b * L + l;
    if (n < N)
      for (int t = 0; t < T; t++) s = s + {8'd0, pd[t][n]};
    return s;
  endfunction

  function automatic logic [DW-1:0] beat_data(int b);
    logic [DW-1:0] d;
    logic [W+7:0] s;
    d = '0;
    for (int l = 0; l < L; l++) begin
      s = lane_raw(b, l);
`ifdef DMP_REDUCE_SATURATE_EN
      d[l*W +: W] = (s > MAXV) ? {W{1'b1}} : s[W-1:0];
`else
      d[l*W +: W] = s[W-1:0];
`endif
    end
    return d;
  endfunction

  function automatic bit beat_sat(int b);
    bit r;
    r = 0;
`ifdef DMP_REDUCE_SATURATE_EN
    for (int l = 0; l < L; l++) if (lane_raw(b, l) > MAXV) r = 1;
`endif
    return r;
  endfunction

  function automatic logic [L-1:0] beat_mask(int b);
    logic [L-1:0] m;
    for (int l = 0; l < L; l++) m[l] = (b * L + l < N);
    return m;
  endfunction

  // Check what the DUT shows now, then advance the model with the inputs
  // the next rising edge will sample.
  always @(negedge clock) begin
    if (m_live) begin
      chk("out_valid", out_valid, m_phase == 1);
      chk("busy", busy, m_phase == 1);
      chk("stream_start", stream_start, m_phase == 1 && m_beat == 0);
      chk("stream_done", stream_done, m_done);
      chk("overflow", overflow, m_ovf);
      if (m_phase == 1) begin
        chk("out_data", out_data, beat_data(m_beat));
        chk("out_lane_mask", out_lane_mask, beat_mask(m_beat));
        chk("out_base_id", out_base_id, m_beat * L);
        chk("out_last", out_last, m_beat == NB - 1);
      end else if (m_clear) begin
        chk("rst_data", out_data, 0);
        chk("rst_mask", out_lane_mask, 0);
        chk("rst_base", out_base_id, 0);
        chk("rst_last", out_last, 0);
      end
      if (out_valid === 1'b1 && out_ready && !next_iteration && reset_n) dut_hs++;
    end
    m_done = 0;
    if (!reset_n) begin
      m_live = 1; m_phase = 0; m_mask = '0; m_beat = 0; m_clear = 1; m_ovf = 0;
    end else if (m_live) begin
      if (next_iteration) begin
        m_phase = 0; m_mask = '0;
      end else if (m_phase == 0) begin
        m_mask = m_mask | thread_done;
        if (&m_mask) begin
          m_phase = 1; m_beat = 0; m_clear = 0;
          m_ovf = m_ovf | beat_sat(0);
        end
      end else if (m_phase == 1 && out_ready) begin
        if (m_beat == NB - 1) begin
          m_phase = 2; m_done = 1;
        end else begin
          m_beat++;
          m_ovf = m_ovf | beat_sat(m_beat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    next_iteration = 1'b0;
    thread_done    = '0;
    bp++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (bp % 4 == 0) || (bp % 4 == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic set_pd(input int mode);
    for (int t = 0; t < T; t++)
      for (int n = 0; n < N; n++)
        case (mode)
          0: pd[t][n] = RANK_ONE;
          1: pd[t][n] = {32'h0, $urandom};
          2: pd[t][n] = {$urandom, $urandom};
          default: pd[t][n] = (n == 0 && t == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 :
                              (n == 0 && t == 1) ? 64'h20 : 64'h0;
        endcase
  endtask

  task automatic send_done(input int mode);
    logic [T-1:0] sent;
    int k;
    sent = '0;
    k = 0;
    while (sent != '1 && k < 40) begin
      case (mode)
        0:       thread_done = '1;
        1:       thread_done = T'(1) << k;
        default: thread_done = T'($urandom) & T'($urandom);
      endcase
      sent = sent | thread_done;
      k++;
      tick();
    end
    if (sent != '1) begin
      thread_done = ~sent;
      tick();
    end
  endtask

  task automatic go_stream(input int abort_at, input bit noise);
    int budget;
    budget = 2000;
    while (m_phase != 2 && budget > 0) begin
      if (abort_at >= 0 && m_phase == 1 && m_beat == abort_at) begin
        out_ready = 1'b1;
        next_iteration = 1'b1;
        tick();
        return;
      end
      if (noise) thread_done = T'($urandom);
      tick();
      budget--;
    end
    if (budget == 0) chk("stream_timeout", m_phase, 2);
  endtask

  task automatic finish_iter();
    chk("hs_count", dut_hs, NB);
    next_iteration = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; next_iteration = 1'b0; thread_done = '0; out_ready = 1'b1;
    set_pd(0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // all-ones reduction, free-flowing sink
    rdy_mode = 0; dut_hs = 0;
    send_done(0); go_stream(-1, 0); finish_iter();

    // staggered thread completion, random sink, stray done bits while streaming
    set_pd(1); rdy_mode = 2; dut_hs = 0;
    send_done(1); go_stream(-1, 1); finish_iter();

    // 1,0,0,1 back-pressure with wrapping sums
    set_pd(2); rdy_mode = 1; dut_hs = 0;
    send_done(0); go_stream(-1, 0); finish_iter();

    // abort on beat 3, then restream from beat 0
    set_pd(1); rdy_mode = 0; dut_hs = 0;
    send_done(0); go_stream(3, 0);
    chk("abort_hs", dut_hs, 3);
    tick();
    dut_hs = 0;
    send_done(2); go_stream(-1, 0); finish_iter();

    // saturation / wrap on node 0
    set_pd(3); rdy_mode = 0; dut_hs = 0;
    send_done(0); go_stream(-1, 0); finish_iter();
    tick();
`ifdef DMP_REDUCE_SATURATE_EN
    chk("ovf_persist", overflow, 1);
`else
    chk("ovf_persist", overflow, 0);
`endif

    for (int i = 0; i < 12; i++) begin
      set_pd($urandom_range(1, 2));
      rdy_mode = $urandom_range(0, 2);
      dut_hs = 0;
      send_done($urandom_range(0, 2));
      if (i == 6) begin
        repeat (4) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
      end else if ($urandom_range(0, 3) == 0) begin
        int a;
        a = $urandom_range(0, NB - 1);
        go_stream(a, 1);
        chk("abort_hs", dut_hs, a);
      end else begin
        go_stream(-1, 1);
        finish_iter();
      end
    end

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
